// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-to-consumer byte buffer signal bundle
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_W      = 3
);
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  rd_en;
    logic                  clr_ovf;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic [PTR_W:0]        count;
    logic                  overflow;

    modport master (
        output wr_data, wr_valid, rd_en, clr_ovf,
        input  rd_data, rd_valid, empty, full, almost_full, count, overflow
    );

    modport slave (
        input  wr_data, wr_valid, rd_en, clr_ovf,
        output rd_data, rd_valid, empty, full, almost_full, count, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffers received UART bytes until the consumer pops them
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_W      = 3,
    parameter int AF_LEVEL   = 6
) (
    input logic            clk,
    input logic            rst,
    uart_rx_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << PTR_W;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d, overflow_q, overflow_d;
    logic                  empty, full, pop_ok, push_ok;

    assign count           = wr_ptr_q - rd_ptr_q;
    assign empty           = count == '0;
    assign full            = count == (PTR_W+1)'(DEPTH);
    assign bus.count       = count;
    assign bus.empty       = empty;
    assign bus.full        = full;
    assign bus.almost_full = count >= (PTR_W+1)'(AF_LEVEL);
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.overflow    = overflow_q;

    // Next-state: a pop frees a slot so a push into a full buffer still lands; a pop on empty is ignored.
    always_comb begin
        pop_ok     = bus.rd_en & ~empty;
        push_ok    = bus.wr_valid & (~full | pop_ok);
        wr_ptr_d   = wr_ptr_q + {{PTR_W{1'b0}}, push_ok};
        rd_ptr_d   = rd_ptr_q + {{PTR_W{1'b0}}, pop_ok};
        rd_data_d  = pop_ok ? mem[rd_ptr_q[PTR_W-1:0]] : rd_data_q;
        rd_valid_d = pop_ok;
        overflow_d = (bus.wr_valid & ~push_ok) | (overflow_q & ~bus.clr_ovf);
    end

    // Storage is deliberately not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q[PTR_W-1:0]] <= bus.wr_data;
    end

    // Control state, cleared asynchronously so a reset discards contents at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: queue-model and directed-vector bench for uart_rx_fifo
module tb_uart_rx_fifo;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    uart_rx_fifo_if #(.DATA_WIDTH(8), .PTR_W(3)) bus ();
    uart_rx_fifo #(.DATA_WIDTH(8), .PTR_W(3), .AF_LEVEL(AF)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: a plain byte queue plus the three registered outputs.
    logic [7:0] q[$];
    logic [7:0] m_rd_data  = 8'h00;
    logic       m_rd_valid = 1'b0;
    logic       m_ovf      = 1'b0;

    // Advance the model on each clock edge; reset empties it immediately.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_rd_data  <= 8'h00;
            m_rd_valid <= 1'b0;
            m_ovf      <= 1'b0;
        end else begin
            automatic bit pop  = bus.rd_en && q.size() > 0;
            automatic bit push = bus.wr_valid && (q.size() < DEPTH || pop);
            m_rd_valid <= pop;
            if (pop) begin
                m_rd_data <= q[0];
                q.pop_front();
            end
            if (push) q.push_back(bus.wr_data);
            if (bus.wr_valid && !push) m_ovf <= 1'b1;
            else if (bus.clr_ovf) m_ovf <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("model rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
        chk("model rd_data", 32'(bus.rd_data), 32'(m_rd_data));
        chk("model count", 32'(bus.count), q.size());
        chk("model empty", 32'(bus.empty), 32'(q.size() == 0));
        chk("model full", 32'(bus.full), 32'(q.size() == DEPTH));
        chk("model almost_full", 32'(bus.almost_full), 32'(q.size() >= AF));
        chk("model overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic cyc(input logic wv, input logic [7:0] wd, input logic re, input logic co);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_en    = re;
        bus.clr_ovf  = co;
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        bus.rd_en    = 1'b0;
        bus.clr_ovf  = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop_exp(input logic [7:0] d);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop rd_valid", 32'(bus.rd_valid), 32'd1);
        chk("pop rd_data", 32'(bus.rd_data), 32'(d));
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.rd_en    = 1'b0;
        bus.clr_ovf  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset count", 32'(bus.count), 32'd0);
        chk("reset empty", 32'(bus.empty), 32'd1);
        chk("reset rd_data", 32'(bus.rd_data), 32'd0);
        rst = 1'b0;
        fork
            forever begin
                @(negedge clk);
                compare();
            end
        join_none

        push(8'hA5); push(8'h3C); push(8'hFF);
        chk("t1 count", 32'(bus.count), 32'd3);
        chk("t1 empty", 32'(bus.empty), 32'd0);
        pop_exp(8'hA5); pop_exp(8'h3C); pop_exp(8'hFF);
        chk("t1 drained empty", 32'(bus.empty), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t1 rd_valid drops", 32'(bus.rd_valid), 32'd0);

        for (int i = 0; i < 8; i++) begin
            push(8'(i));
            chk("t2 almost_full", 32'(bus.almost_full), 32'(i >= 5));
            chk("t2 full", 32'(bus.full), 32'(i == 7));
        end
        push(8'h55);
        chk("t2 overflow", 32'(bus.overflow), 32'd1);
        chk("t2 count", 32'(bus.count), 32'd8);
        for (int i = 0; i < 8; i++) pop_exp(8'(i));
        chk("t2 overflow sticky", 32'(bus.overflow), 32'd1);
        chk("t2 empty", 32'(bus.empty), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t2 clr_ovf", 32'(bus.overflow), 32'd0);

        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        cyc(1'b1, 8'h99, 1'b1, 1'b0);
        chk("t3 rd_data", 32'(bus.rd_data), 32'h10);
        chk("t3 count", 32'(bus.count), 32'd8);
        chk("t3 overflow", 32'(bus.overflow), 32'd0);
        for (int i = 1; i < 8; i++) pop_exp(8'h10 + 8'(i));
        pop_exp(8'h99);

        cyc(1'b1, 8'h42, 1'b1, 1'b0);
        chk("t4 rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("t4 count", 32'(bus.count), 32'd1);
        pop_exp(8'h42);

        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5 empty rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("t5 empty rd_data held", 32'(bus.rd_data), 32'h42);
        for (int i = 0; i < 20; i++) begin
            push(8'h60 + 8'(i));
            if (i % 3 == 0) push(8'hE0 + 8'(i));
            if (i % 4 == 1) cyc(1'b0, 8'h00, 1'b0, 1'b0);
            pop_exp(8'h60 + 8'(i));
            if (i % 3 == 0) pop_exp(8'hE0 + 8'(i));
        end
        chk("t5 empty after wrap", 32'(bus.empty), 32'd1);

        for (int i = 0; i < 9; i++) push(8'h70 + 8'(i));
        for (int i = 0; i < 3; i++) pop_exp(8'h70 + 8'(i));
        chk("t6 count before", 32'(bus.count), 32'd5);
        chk("t6 overflow before", 32'(bus.overflow), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t6 async count", 32'(bus.count), 32'd0);
        chk("t6 async empty", 32'(bus.empty), 32'd1);
        chk("t6 async overflow", 32'(bus.overflow), 32'd0);
        chk("t6 async rd_data", 32'(bus.rd_data), 32'd0);
        chk("t6 async almost_full", 32'(bus.almost_full), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        push(8'hC3);
        chk("t6 fresh count", 32'(bus.count), 32'd1);
        pop_exp(8'hC3);
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
